// File: rtl/add_cla_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready handshakes.
// Define ADD_CLA_SAT_EN to saturate out_sum to the signed limit on overflow.
module add_cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    // Operands are zero-padded to whole 16-bit blocks; padding has p=g=0.
    localparam int NBLK = (WIDTH + 15) / 16;
    localparam int PW   = NBLK * 16;

    function automatic logic [4:0] look4(input logic [3:0] p, input logic [3:0] g, input logic c);
        logic [4:0] r;
        r[0] = c;
        r[1] = g[0] | (p[0] & c);
        r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        r[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c);
        return r;
    endfunction

    function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [WIDTH-1:0]  bb_s, sum_raw_s, sum_s;
    logic [PW-1:0]     a_x_s, b_x_s, p_s, g_s;
    logic [PW:0]       c_s;
    logic [3:0]        gp_s, gg_s;
    logic [4:0]        gc_s, bc_s;
    logic              c0_s, cout_s, ovf_s, zero_s;

    logic [STAGES-1:0] v_r, adv_s, cout_r, ovf_r, zero_r;
    logic [WIDTH-1:0]  sum_r [STAGES];

    // Full result (carry lookahead, flags, optional saturation) ahead of slot 0.
    always_comb begin
        bb_s  = in_sub ? ~in_b : in_b;
        c0_s  = in_sub ? ~in_cin : in_cin;
        a_x_s = {PW{1'b0}};
        b_x_s = {PW{1'b0}};
        a_x_s[WIDTH-1:0] = in_a;
        b_x_s[WIDTH-1:0] = bb_s;
        p_s   = a_x_s | b_x_s;
        g_s   = a_x_s & b_x_s;
        c_s   = {(PW+1){1'b0}};
        gp_s  = 4'b0000;
        gg_s  = 4'b0000;
        gc_s  = 5'b00000;
        bc_s  = 5'b00000;
        c_s[0] = c0_s;
        for (int blk = 0; blk < NBLK; blk++) begin
            for (int grp = 0; grp < 4; grp++) begin
                gp_s[grp] = &p_s[blk*16 + grp*4 +: 4];
                gg_s[grp] = grp_gen(p_s[blk*16 + grp*4 +: 4], g_s[blk*16 + grp*4 +: 4]);
            end
            gc_s = look4(gp_s, gg_s, c_s[blk*16]);
            for (int grp = 0; grp < 4; grp++) begin
                bc_s = look4(p_s[blk*16 + grp*4 +: 4], g_s[blk*16 + grp*4 +: 4], gc_s[grp]);
                c_s[blk*16 + grp*4 + 1 +: 4] = bc_s[4:1];
            end
            c_s[blk*16 + 16] = gc_s[4];
        end
        sum_raw_s = in_a ^ bb_s ^ c_s[WIDTH-1:0];
        cout_s    = c_s[WIDTH];
        ovf_s     = (in_a[WIDTH-1] == bb_s[WIDTH-1]) && (sum_raw_s[WIDTH-1] != in_a[WIDTH-1]);
`ifdef ADD_CLA_SAT_EN
        if (ovf_s) begin
            sum_s = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_s = sum_raw_s;
        end
`else
        sum_s = sum_raw_s;
`endif
        zero_s = (sum_s == {WIDTH{1'b0}});
    end

    // Per-slot advance: a slot moves when its successor is empty or itself moves.
    always_comb begin
        logic ok;
        adv_s = {STAGES{1'b0}};
        ok    = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv_s[k] = v_r[k] & ok;
            ok       = ~v_r[k] | adv_s[k];
        end
    end

    assign in_ready = ~v_r[0] | adv_s[0];

    // Slot registers: capture into slot 0, shift forward, hold when stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r    <= {STAGES{1'b0}};
            cout_r <= {STAGES{1'b0}};
            ovf_r  <= {STAGES{1'b0}};
            zero_r <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                sum_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            if (in_valid && in_ready) begin
                v_r[0]    <= 1'b1;
                sum_r[0]  <= sum_s;
                cout_r[0] <= cout_s;
                ovf_r[0]  <= ovf_s;
                zero_r[0] <= zero_s;
            end else if (adv_s[0]) begin
                v_r[0] <= 1'b0;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv_s[k-1]) begin
                    v_r[k]    <= 1'b1;
                    sum_r[k]  <= sum_r[k-1];
                    cout_r[k] <= cout_r[k-1];
                    ovf_r[k]  <= ovf_r[k-1];
                    zero_r[k] <= zero_r[k-1];
                end else if (adv_s[k]) begin
                    v_r[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign out_sum   = sum_r[STAGES-1];
    assign out_cout  = cout_r[STAGES-1];
    assign out_ovf   = ovf_r[STAGES-1];
    assign out_zero  = zero_r[STAGES-1];
endmodule

// File: tb/tb_add_cla_pipe.sv
// Randomised and directed bench for add_cla_pipe: a 32-bit/2-stage and a 64-bit/4-stage
// instance share stimulus; sel picks which one is driven and observed.
module tb_add_cla_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel, in_valid, in_sub, in_cin, out_ready;
    logic [63:0] in_a, in_b;
    logic        r32, ov32, c32, o32, z32;
    logic [31:0] s32;
    logic        r64, ov64, c64, o64, z64;
    logic [63:0] s64;
    logic        v32_in, v64_in;

    assign v32_in = in_valid & ~sel;
    assign v64_in = in_valid & sel;

    add_cla_pipe #(.WIDTH(32), .STAGES(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32_in), .in_ready(r32),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(ov32), .out_ready(out_ready), .out_sum(s32),
        .out_cout(c32), .out_ovf(o32), .out_zero(z32));

    add_cla_pipe #(.WIDTH(64), .STAGES(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64_in), .in_ready(r64),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(ov64), .out_ready(out_ready), .out_sum(s64),
        .out_cout(c64), .out_ovf(o64), .out_zero(z64));

    logic        obs_rdy, obs_valid, obs_cout, obs_ovf, obs_zero;
    logic [63:0] obs_sum;
    assign obs_rdy   = sel ? r64 : r32;
    assign obs_valid = sel ? ov64 : ov32;
    assign obs_sum   = sel ? s64 : {32'd0, s32};
    assign obs_cout  = sel ? c64 : c32;
    assign obs_ovf   = sel ? o64 : o32;
    assign obs_zero  = sel ? z64 : z32;

    typedef struct packed { logic [63:0] sum; logic cout; logic ovf; logic zero; } res_t;
    typedef struct { logic [63:0] a; logic [63:0] b; logic sub; logic cin; } stim_t;
    typedef struct { res_t r; int acc; } exp_t;

    stim_t stim[$];
    exp_t  exp_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    int    pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

    // Reference: plain wide arithmetic on the selected width.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input logic cin, input logic wide);
        int w;
        logic [63:0] mask, am, bm;
        logic [64:0] t;
        res_t r;
        w    = wide ? 64 : 32;
        mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        am   = a & mask;
        bm   = (sub ? ~b : b) & mask;
        t    = {1'b0, am} + {1'b0, bm} + {64'd0, (sub ? ~cin : cin)};
        r.sum  = t[63:0] & mask;
        r.cout = wide ? t[64] : t[32];
        r.ovf  = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
`ifdef ADD_CLA_SAT_EN
        if (r.ovf) r.sum = am[w-1] ? (64'd1 << (w-1)) : (mask >> 1);
`endif
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    task automatic push(input logic [63:0] a, input logic [63:0] b, input logic sub, input logic cin);
        stim_t s;
        s.a = a; s.b = b; s.sub = sub; s.cin = cin;
        stim.push_back(s);
    endtask

    task automatic add_rand(input int n);
        for (int i = 0; i < n; i++) begin
            stim_t s;
            s.a   = {$urandom, $urandom};
            s.b   = {$urandom, $urandom};
            s.sub = 1'($urandom_range(0, 1));
            s.cin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) s.b = s.sub ? s.a : ~s.a;
            stim.push_back(s);
        end
    endtask

    // Drive the stim queue through the selected DUT and check every cycle.
    // mode 0: always ready (exact latency), 1: fixed ready pattern, 2: random valid/ready.
    task automatic run(input int mode);
        int cyc, sent, limit, stg;
        logic hv, hc, ho, hz, exp_rdy, exp_ov;
        logic [63:0] hs;
        exp_t x;
        cyc = 0; sent = 0; hv = 1'b0; hs = 64'd0; hc = 1'b0; ho = 1'b0; hz = 1'b0;
        stg = sel ? 4 : 2;
        limit = 20 * stim.size() + 40;
        exp_q.delete();
        while ((sent < stim.size() || exp_q.size() > 0) && cyc < limit) begin
            @(negedge clk);
            in_valid = (sent < stim.size()) && (mode != 2 || $urandom_range(0, 3) != 0);
            if (sent < stim.size()) begin
                in_a = stim[sent].a; in_b = stim[sent].b;
                in_sub = stim[sent].sub; in_cin = stim[sent].cin;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (pat[cyc % 8] == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (hv) begin
                tests_run++;
                if (obs_valid !== 1'b1 || obs_sum !== hs || obs_cout !== hc || obs_ovf !== ho || obs_zero !== hz) begin
                    tests_failed++;
                    $display("FAIL stall_hold cyc=%0d: got valid=%b sum=%h c=%b o=%b z=%b, required valid=1 sum=%h c=%b o=%b z=%b",
                             cyc, obs_valid, obs_sum, obs_cout, obs_ovf, obs_zero, hs, hc, ho, hz);
                end
            end
            exp_rdy = (exp_q.size() < stg) || out_ready;
            tests_run++;
            if (obs_rdy !== exp_rdy) begin
                tests_failed++;
                $display("FAIL in_ready cyc=%0d: got %b, required %b (in flight %0d)", cyc, obs_rdy, exp_rdy, exp_q.size());
            end
            if (mode == 0 || exp_q.size() == 0) begin
                exp_ov = (exp_q.size() > 0) && (cyc - exp_q[0].acc >= stg);
                tests_run++;
                if (obs_valid !== exp_ov) begin
                    tests_failed++;
                    $display("FAIL out_valid cyc=%0d: got %b, required %b", cyc, obs_valid, exp_ov);
                end
            end
            if (obs_valid === 1'b1 && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL extra_beat cyc=%0d: got sum=%h, required no beat", cyc, obs_sum);
                end else begin
                    x = exp_q.pop_front();
                    if (obs_sum !== x.r.sum || obs_cout !== x.r.cout || obs_ovf !== x.r.ovf || obs_zero !== x.r.zero) begin
                        tests_failed++;
                        $display("FAIL result cyc=%0d: got sum=%h c=%b o=%b z=%b, required sum=%h c=%b o=%b z=%b",
                                 cyc, obs_sum, obs_cout, obs_ovf, obs_zero, x.r.sum, x.r.cout, x.r.ovf, x.r.zero);
                    end
                end
            end
            hv = (obs_valid === 1'b1) && !out_ready;
            hs = obs_sum; hc = obs_cout; ho = obs_ovf; hz = obs_zero;
            if (in_valid && obs_rdy === 1'b1) begin
                x.r = model(stim[sent].a, stim[sent].b, stim[sent].sub, stim[sent].cin, sel);
                x.acc = cyc;
                exp_q.push_back(x);
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (sent < stim.size() || exp_q.size() > 0) begin
            tests_failed++;
            $display("FAIL timeout: got %0d sent, %0d pending after %0d cycles, required all %0d drained",
                     sent, exp_q.size(), cyc, stim.size());
        end
    endtask

    task automatic check_idle_zero(input string name);
        tests_run++;
        if (obs_valid !== 1'b0 || obs_sum !== 64'd0 || obs_cout !== 1'b0 || obs_ovf !== 1'b0 ||
            obs_zero !== 1'b0 || obs_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s sel=%b: got valid=%b sum=%h c=%b o=%b z=%b rdy=%b, required all zero with rdy=1",
                     name, sel, obs_valid, obs_sum, obs_cout, obs_ovf, obs_zero, obs_rdy);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_idle_zero("reset_state");
        end
    endtask

    task automatic test_directed();
        sel = 1'b0;
        stim.delete();
        push(64'h0000_FFFF, 64'h1, 1'b0, 1'b0);
        push(64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0);
        push(64'h7, 64'h5, 1'b1, 1'b0);
        push(64'h5, 64'h7, 1'b1, 1'b0);
        push(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);
        push(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b1);
        push(64'h8000_0000, 64'h1, 1'b1, 1'b0);
        push(64'h0000_0000, 64'h0, 1'b1, 1'b1);
        run(0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        stim.delete();
        for (int i = 0; i < 8; i++) push(64'(i), 64'(100 * i), 1'b0, 1'b0);
        run(1);
    endtask

    task automatic test_random(input logic wide, input int n);
        sel = wide;
        stim.delete();
        add_rand(n);
        run(0);
        stim.delete();
        add_rand(n);
        run(2);
    endtask

    task automatic test_wide_directed();
        sel = 1'b1;
        stim.delete();
        push(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        push(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        push(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        push(64'h0000_0000_0001_0000, 64'h1, 1'b1, 1'b0);
        run(0);
    endtask

    task automatic test_reset_midop(input logic wide);
        int stg;
        sel = wide;
        stg = wide ? 4 : 2;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 64'h1234 + 64'(i); in_b = 64'h10; in_sub = 1'b0; in_cin = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle_zero("midop_reset");
        out_ready = 1'b1;
        for (int i = 0; i < 2 * stg + 2; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (obs_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stale_after_reset sel=%b: got out_valid=%b sum=%h, required out_valid=0", sel, obs_valid, obs_sum);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_a = 64'd0; in_b = 64'd0;
        in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random(1'b0, 150);
        test_reset_midop(1'b0);
        test_wide_directed();
        test_random(1'b1, 100);
        test_reset_midop(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
